// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// and buffers tagged responses in a small FIFO that serves as the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [32:0] br_data,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fs_valid,
  input  logic        fs_ready,
  output logic [63:0] fs_ds_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDIT_LIM = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state, state_next;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding, drop_cnt, drop_next, count;
  logic [AW-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [63:0]   fifo_mem [FIFO_DEPTH];
  logic [31:0]   tag_mem  [FIFO_DEPTH];
  logic [CW:0]   credit_used;
  logic          req_fire, deq, redirect, push;

  assign redirect    = br_data[0];
  assign fs_valid    = !rst && (count != '0);
  assign fs_ds_data  = fs_valid ? fifo_mem[rd_ptr] : '0;
  assign deq         = fs_valid && fs_ready;
  // Entries already buffered and requests still in flight share the same FIFO_DEPTH credit pool.
  assign credit_used = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, deq};
  assign imem_req_valid = !rst && !redirect && (credit_used < CREDIT_LIM);
  assign imem_req_addr  = pc;
  assign req_fire    = imem_req_valid && imem_req_ready;
  assign push        = imem_rsp_valid && (state == RUN) && !redirect;

  always_comb begin
    state_next = state;
    drop_next  = drop_cnt;
    if (redirect) begin
      // Every request still in flight belongs to the abandoned path.
      drop_next  = outstanding - CW'(imem_rsp_valid);
      state_next = (drop_next != '0) ? FLUSH : RUN;
    end else if (state == FLUSH && imem_rsp_valid) begin
      drop_next = drop_cnt - 1'b1;
      if (drop_cnt == CW'(1)) state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      assert (!(push && count == CW'(FIFO_DEPTH)));
      state    <= state_next;
      drop_cnt <= drop_next;
      if (req_fire && !imem_rsp_valid)      outstanding <= outstanding + 1'b1;
      else if (!req_fire && imem_rsp_valid) outstanding <= outstanding - 1'b1;
      if (redirect) begin
        pc     <= br_data[32:1] & 32'hFFFF_FFFC;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        tag_wr <= '0;
        tag_rd <= '0;
      end else begin
        if (req_fire) begin
          pc     <= pc + 32'd4;
          tag_wr <= tag_wr + 1'b1;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          tag_rd <= tag_rd + 1'b1;
        end
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= pc;
    if (push)     fifo_mem[wr_ptr] <= {imem_rsp_data, tag_mem[tag_rd]};
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model with variable latency and a
// scoreboard of expected {instr, pc} entries pushed on request acceptance.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam int          FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [32:0] br_data;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fs_valid;
  logic        fs_ready;
  logic [63:0] fs_ds_data;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .br_data(br_data),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .fs_valid(fs_valid), .fs_ready(fs_ready),
    .fs_ds_data(fs_ds_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [63:0] exp_q[$];

  int          errors = 0, checks = 0, cyc = 0, last_due = 0, delivered = 0;
  int          lat_min = 1, lat_max = 1, rdy_pct = 100, fsr_pct = 100;
  logic        rst_want = 1'b1;
  logic        last_fs_valid = 1'b0;
  bit          did_br = 0, first_armed = 0;
  logic [31:0] first_exp = '0, exp_addr = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, observe combinational outputs before the next posedge.
  task automatic step(input bit br_req, input bit br_force, input logic [31:0] br_tgt);
    int lat, due;
    @(negedge clk);
    rst     = rst_want;
    did_br  = 0;
    br_data = '0;
    if (!rst_want && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(rsp_q[0].addr);
      void'(rsp_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    fs_ready       = ($urandom_range(99) < fsr_pct);
    #1;
    if (br_req && !rst_want && (fs_valid || br_force)) begin
      br_data  = {br_tgt, 1'b1};
      fs_ready = 1'b1;
      did_br   = 1;
    end
    #1;
    last_fs_valid = fs_valid;
    if (rst_want) begin
      check_val("rst_fs_valid", fs_valid, 0);
      check_val("rst_req_valid", imem_req_valid, 0);
      check_val("rst_data", fs_ds_data, 0);
      rsp_q.delete();
      exp_q.delete();
      exp_addr    = RESET_PC;
      first_armed = 0;
    end else begin
      if (fs_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_valid", fs_valid, 0);
        end else begin
          check_val("head_data", fs_ds_data, exp_q[0]);
          if (fs_ready) begin
            void'(exp_q.pop_front());
            delivered++;
            if (first_armed) begin
              check_val("first_pc_after_br", fs_ds_data[31:0], first_exp);
              first_armed = 0;
            end
          end
        end
      end else begin
        check_val("empty_data", fs_ds_data, 0);
      end
      if (did_br) begin
        check_val("br_noreq", imem_req_valid, 0);
        exp_q.delete();
        exp_addr    = {br_tgt[31:2], 2'b00};
        first_armed = 1;
        first_exp   = exp_addr;
      end else if (imem_req_valid) begin
        check_val("req_addr", imem_req_addr, exp_addr);
        if (imem_req_ready) begin
          lat = $urandom_range(lat_max, lat_min);
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          rsp_q.push_back('{exp_addr, due});
          exp_q.push_back({mem_word(exp_addr), exp_addr});
          exp_addr += 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_branch(input logic [31:0] tgt);
    int n;
    n = 0;
    did_br = 0;
    while (!did_br && n < 20) begin
      step(1, 0, tgt);
      n++;
    end
    if (!did_br) check_val("br_timeout", 0, 1);
  endtask

  initial begin
    int first_v;
    rst = 1'b1; br_data = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; fs_ready = 1'b0;

    rst_want = 1'b1;
    repeat (3) step(0, 0, '0);

    // Latency and sustained throughput with 1-cycle memory.
    rst_want = 1'b0; first_v = -1; delivered = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, '0);
      if (last_fs_valid && first_v < 0) first_v = i;
    end
    check_val("first_latency", first_v, 2);
    check_val("throughput", delivered, 10);

    // Decode stall: FIFO fills to the credit limit, then drains in order.
    fsr_pct = 0;
    repeat (10) step(0, 0, '0);
    check_val("stall_noreq", imem_req_valid, 0);
    check_val("stall_count", dut.count, FIFO_DEPTH);
    check_val("stall_valid", last_fs_valid, 1);
    fsr_pct = 100; delivered = 0;
    repeat (12) step(0, 0, '0);
    check_val("drain_count", delivered, 12);

    // Redirects with requests in flight, unaligned target, and PC wrap.
    lat_min = 2; lat_max = 2;
    repeat (6) step(0, 0, '0);
    do_branch(32'h8000_0100);
    repeat (10) step(0, 0, '0);
    do_branch(32'h8000_0203);
    repeat (10) step(0, 0, '0);
    do_branch(32'hFFFF_FFF8);
    repeat (10) step(0, 0, '0);

    // Second redirect while still flushing the first.
    lat_min = 3; lat_max = 3;
    repeat (8) step(0, 0, '0);
    do_branch(32'h8000_0100);
    step(1, 1, 32'h8000_0400);
    check_val("second_br_taken", did_br, 1);
    repeat (15) step(0, 0, '0);
    check_val("second_br_delivered", first_armed, 0);

    // Random back-pressure and latency.
    lat_min = 1; lat_max = 4; rdy_pct = 50; fsr_pct = 70; delivered = 0;
    repeat (400) step(0, 0, '0);
    check_val("random_progress", delivered > 50, 1);

    // Reset mid-stream with the FIFO full.
    lat_min = 1; lat_max = 1; rdy_pct = 100; fsr_pct = 0;
    repeat (12) step(0, 0, '0);
    check_val("full_before_rst", dut.count, FIFO_DEPTH);
    rst_want = 1'b1;
    step(0, 0, '0);
    rst_want = 1'b0;
    step(0, 0, '0);
    check_val("post_rst_fs_valid", last_fs_valid, 0);
    check_val("post_rst_outstanding", dut.outstanding, 0);
    check_val("post_rst_addr", imem_req_addr, RESET_PC);
    fsr_pct = 100;
    repeat (10) step(0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
